// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: a CPU and a loader/DMA share one single-cycle memory.
// Each access takes one grant cycle in IDLE, one ISSUE cycle and one RESP cycle; contested grants alternate.
module dmem_arbiter #(
  parameter int              AW        = 32,
  parameter logic [AW-1:0]   FLAG_ADDR = AW'(32'h02000008)
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,

  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic [31:0]   dma_rdata,
  output logic          dma_ack,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,

  output logic          flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_t;

  state_t        state;
  gnt_t          last_grant;
  gnt_t          grant_id;
  logic          lat_we;
  logic          cpu_ack_q;
  logic          dma_ack_q;
  logic [31:0]   cpu_rdata_q;
  logic [31:0]   dma_rdata_q;

  gnt_t          winner;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [31:0]   win_wdata;

  // DMA wins only when alone or when the CPU had the previous grant.
  always_comb begin
    winner    = GNT_CPU;
    if (dma_req && (!cpu_req || last_grant == GNT_CPU)) begin
      winner = GNT_DMA;
    end
    win_we    = (winner == GNT_DMA) ? dma_we    : cpu_we;
    win_addr  = (winner == GNT_DMA) ? dma_addr  : cpu_addr;
    win_wdata = (winner == GNT_DMA) ? dma_wdata : cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GNT_DMA;
      grant_id    <= GNT_CPU;
      lat_we      <= 1'b0;
      flag        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            grant_id   <= winner;
            last_grant <= winner;
            lat_we     <= win_we;
            mem_addr   <= win_addr;
            mem_wdata  <= win_wdata;
            mem_en     <= 1'b1;
            mem_we     <= win_we;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (grant_id == GNT_CPU && lat_we && mem_addr == FLAG_ADDR) begin
            flag <= 1'b1;
          end
          cpu_ack_q <= (grant_id == GNT_CPU);
          dma_ack_q <= (grant_id == GNT_DMA);
          state     <= RESP;
        end
        RESP: begin
          // Memory data is only present during RESP, so loads are captured for later cycles.
          if (!lat_we) begin
            if (grant_id == GNT_CPU) begin
              cpu_rdata_q <= mem_rdata;
            end else begin
              dma_rdata_q <= mem_rdata;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset landing on the RESP cycle suppresses the pending acknowledge.
  assign cpu_ack   = cpu_ack_q & ~reset;
  assign dma_ack   = dma_ack_q & ~reset;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign cpu_rdata = (cpu_ack && !lat_we) ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = (dma_ack && !lat_we) ? mem_rdata : dma_rdata_q;

  assert property (@(posedge clk) disable iff (reset) mem_en |-> state == ISSUE);
  assert property (@(posedge clk) disable iff (reset) !(cpu_ack_q && dma_ack_q));
  assert property (@(posedge clk) disable iff (reset) state == ISSUE |=> state == RESP);

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of both requester ports and the memory port.
REQ-002 Parameter: FLAG_ADDR, 32'h02000008, CPU store address that sets the done flag.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 cpu_req  in  1  CPU data access request; held high with fields stable until cpu_ack.
REQ-006 cpu_we  in  1  CPU access is a store (1) or load (0).
REQ-007 cpu_addr  in  AW  CPU byte address.
REQ-008 cpu_wdata  in  32  CPU store data.
REQ-009 cpu_rdata  out  32  CPU load data; valid in the cycle cpu_ack=1.
REQ-010 cpu_ack  out  1  one-cycle completion pulse for the CPU access.
REQ-011 cpu_stall  out  1  combinational cpu_req & ~cpu_ack; freezes CPU PC/register writeback.
REQ-012 dma_req, dma_we, dma_addr(AW), dma_wdata(32)  in  loader/DMA request fields; same hold rule as CPU.
REQ-013 dma_rdata  out  32  DMA load data; valid when dma_ack=1.
REQ-014 dma_ack  out  1  one-cycle completion pulse for the DMA access.
REQ-015 mem_en, mem_we  out  1  memory strobe and write enable.
REQ-016 mem_addr  out  AW; mem_wdata  out  32  registered copy of the granted requester's fields.
REQ-017 mem_rdata  in  32  memory read data, valid exactly one cycle after mem_en with mem_we=0.
REQ-018 flag  out  1  sticky done flag.

Function
REQ-019 FSM states: IDLE, ISSUE, RESP; each access occupies exactly one ISSUE and one RESP cycle.
REQ-020 IDLE: no request -> stay IDLE; one request -> grant it; both -> grant the requester not granted last (round-robin via 1-bit last_grant).
REQ-021 On grant, the arbiter SHALL latch we/addr/wdata of the winner and the grant id, update last_grant, and go to ISSUE.
REQ-022 ISSUE: mem_en=1, mem_we/addr/wdata from the latched fields; next state RESP unconditionally.
REQ-023 RESP: the granted ack=1 for one cycle, rdata=mem_rdata (loads) or unchanged (stores); next state IDLE.
REQ-024 The latency from a req sampled in IDLE to the ack SHALL be 3 cycles (grant, ISSUE, RESP); a new grant SHALL not occur before the following IDLE cycle.
REQ-025 A request arriving while not in IDLE SHALL wait; requester deassertion before ack SHALL not abort an access already granted.
REQ-026 With both requesters continuously requesting, grants SHALL alternate CPU, DMA, CPU, ... with no starvation.
REQ-027 Outside ISSUE, mem_en=0 and mem_we=0.
REQ-028 flag SHALL set at the end of ISSUE when the grant is CPU, the latched we=1 and the latched addr==FLAG_ADDR; the store is still performed to memory; flag clears only on reset.
REQ-029 DMA stores to FLAG_ADDR SHALL not set flag.
REQ-030 cpu_rdata and dma_rdata SHALL hold their last loaded value between accesses.

Reset
REQ-031 On reset: state=IDLE, last_grant=DMA (the first contested grant goes to CPU), flag=0, cpu_ack=dma_ack=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=dma_rdata=0.
REQ-032 Reset asserted mid-access (ISSUE or RESP) SHALL abort it: no ack is produced and the next cycle has mem_en=0.

Verification
REQ-033 CPU load only: cpu_req=1, we=0, addr=0x100, mem returns 0xDEADBEEF -> mem_en at cycle 1, cpu_ack=1 with cpu_rdata=0xDEADBEEF at cycle 2, cpu_stall=1 at cycles 0-1.
REQ-034 Both requesting from reset, held for 4 accesses -> grant order CPU, DMA, CPU, DMA; acks at cycles 2, 5, 8, 11.
REQ-035 CPU store addr=0x02000008, wdata=0x1 -> mem_we=1 in ISSUE, flag=1 from the cycle after ISSUE and stays high; a DMA store to the same address leaves flag=0.
REQ-036 Reset pulsed during ISSUE of a DMA store -> no dma_ack, state IDLE, flag=0; the next CPU request completes in 3 cycles.
REQ-037 DMA store addr=0x20, wdata=0xA5A5A5A5, then CPU load addr=0x20 -> cpu_rdata=0xA5A5A5A5; dma_rdata is unchanged by the CPU load.
